// File: rtl/obi_mem_init_pkg.sv
// Shared types and pattern/address helpers for the OBI memory fill/check engine.
package obi_mem_init_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_AW = 64;
  localparam int unsigned OUT_W  = 4;

  // Word idx carries seed+idx in every 32-bit lane below dw; callers truncate to their width.
  function automatic logic [MAX_DW-1:0] pattern(input logic [31:0] seed, input logic [31:0] idx,
                                                input int unsigned dw);
    logic [MAX_DW-1:0] w;
    w = '0;
    for (int unsigned l = 0; l < MAX_DW/32; l++)
      if (l < dw/32) w[l*32 +: 32] = seed + idx;
    return w;
  endfunction

  function automatic logic [MAX_AW-1:0] addr(input logic [MAX_AW-1:0] base, input logic [31:0] idx,
                                             input int unsigned word_bytes);
    return base + ({32'd0, idx} * MAX_AW'(word_bytes));
  endfunction

endpackage

// File: rtl/obi_mem_init_cnt.sv
// Saturating up-counter with synchronous clear, used for mismatch and error tallies.
module obi_mem_init_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)             cnt_o <= '0;
    else if (inc_i && cnt_o != '1)  cnt_o <= cnt_o + Width'(1);
  end

endmodule

// File: rtl/obi_mem_initiator.sv
// OBI manager that fills (writes) or checks (reads and compares) a contiguous SRAM region,
// one word per transaction, with a bounded number of outstanding requests.
module obi_mem_initiator
  import obi_mem_init_pkg::*;
#(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned LenWidth       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_check_i,
  input  logic [AddrWidth-1:0]   cmd_base_i,
  input  logic [LenWidth-1:0]    cmd_len_i,
  input  logic [31:0]            cmd_seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LenWidth-1:0]    mismatch_cnt_o,
  output logic [LenWidth-1:0]    err_cnt_o,
  output logic [AddrWidth-1:0]   first_mis_addr_o,
  output logic                   first_mis_vld_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  output logic [IdWidth-1:0]     obi_aid_o,
  input  logic                   obi_rvalid_i,
  output logic                   obi_rready_o,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic [IdWidth-1:0]     obi_rid_i,
  input  logic                   obi_err_i
);

  localparam int unsigned BeWidth = DataWidth/8;
  localparam int unsigned OffW    = $clog2(BeWidth);

  state_e                state_q, state_d;
  logic                  check_q;
  logic [AddrWidth-1:0]  base_q;
  logic [LenWidth-1:0]   len_q, iss_q, rsp_q, iss_d;
  logic [31:0]           seed_q;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [AddrWidth-1:0]  first_mis_addr_q, rsp_addr;
  logic                  first_mis_vld_q;
  logic                  cmd_fire, gnt_fire, rsp_fire, rsp_bad, err_inc, mis_inc;
  logic [DataWidth-1:0]  iss_pat, rsp_pat;

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign obi_rready_o = busy_o;
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;

  // Request terms depend only on registered state, so they hold until granted.
  assign obi_req_o = (state_q == ST_RUN) && (iss_q < len_q) && (out_q < OUT_W'(MaxOutstanding));
  assign gnt_fire  = obi_req_o && obi_gnt_i;
  assign rsp_fire  = obi_rvalid_i && (state_q == ST_RUN) && (out_q != '0);

  assign iss_pat     = DataWidth'(pattern(seed_q, 32'(iss_q), DataWidth));
  assign rsp_pat     = DataWidth'(pattern(seed_q, 32'(rsp_q), DataWidth));
  assign obi_addr_o  = AddrWidth'(addr(MAX_AW'(base_q), 32'(iss_q), BeWidth));
  assign rsp_addr    = AddrWidth'(addr(MAX_AW'(base_q), 32'(rsp_q), BeWidth));
  assign obi_we_o    = ~check_q;
  assign obi_be_o    = '1;
  assign obi_wdata_o = check_q ? '0 : iss_pat;
  assign obi_aid_o   = IdWidth'(iss_q);

  // Bus errors take precedence: an errored beat never counts as a data mismatch.
  assign rsp_bad = (obi_rdata_i != rsp_pat) || (obi_rid_i != IdWidth'(rsp_q));
  assign err_inc = rsp_fire && obi_err_i;
  assign mis_inc = rsp_fire && !obi_err_i && check_q && rsp_bad;

  assign iss_d = iss_q + LenWidth'(gnt_fire);

  always_comb begin
    out_d = out_q;
    if (gnt_fire && !rsp_fire)      out_d = out_q + OUT_W'(1);
    else if (!gnt_fire && rsp_fire) out_d = out_q - OUT_W'(1);
  end

  // Looking at next-cycle counts lets done follow the last response by one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_fire) state_d = (cmd_len_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (iss_d == len_q && out_d == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      check_q          <= 1'b0;
      base_q           <= '0;
      len_q            <= '0;
      seed_q           <= '0;
      iss_q            <= '0;
      rsp_q            <= '0;
      out_q            <= '0;
      first_mis_addr_q <= '0;
      first_mis_vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        check_q          <= cmd_check_i;
        base_q           <= {cmd_base_i[AddrWidth-1:OffW], OffW'(0)};
        len_q            <= cmd_len_i;
        seed_q           <= cmd_seed_i;
        iss_q            <= '0;
        rsp_q            <= '0;
        out_q            <= '0;
        first_mis_addr_q <= '0;
        first_mis_vld_q  <= 1'b0;
      end else begin
        iss_q <= iss_d;
        out_q <= out_d;
        if (rsp_fire) rsp_q <= rsp_q + LenWidth'(1);
        if (mis_inc && !first_mis_vld_q) begin
          first_mis_vld_q  <= 1'b1;
          first_mis_addr_q <= rsp_addr;
        end
      end
    end
  end

  assign first_mis_addr_o = first_mis_addr_q;
  assign first_mis_vld_o  = first_mis_vld_q;

  obi_mem_init_cnt #(.Width(LenWidth)) u_mis_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cmd_fire), .inc_i(mis_inc), .cnt_o(mismatch_cnt_o)
  );

  obi_mem_init_cnt #(.Width(LenWidth)) u_err_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cmd_fire), .inc_i(err_inc), .cnt_o(err_cnt_o)
  );

  // A response with nothing in flight is a subordinate protocol violation.
  a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(obi_rvalid_i && out_q == '0));

endmodule
